alu_suma_seq: RTL

Parametrised multi-cycle adder/subtractor that is the sequential successor of the team's combinational ripple adder. It processes the operands DIGIT bits per clock, least-significant digit first, using a start/busy/done handshake. It adds a subtract mode and a signed-overflow flag. It sits in the ALU datapath where area matters more than single-cycle latency; with DIGIT = WIDTH it degenerates to a one-cycle registered adder.

---
 rtl/alu_suma_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_suma_seq.sv
// alu_suma_seq: multi-cycle adder/subtractor, DIGIT bits per clock, LSB digit first.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits processed per clock; must divide WIDTH. N = WIDTH/DIGIT run cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request, sampled while busy = 0 (i.e. in IDLE or DONE)
//   sub        0: a + b + cin, 1: a - b (cin ignored); latched with start
//   cin        carry in for add mode; latched with start
//   a, b       operands; latched with start
//   busy       high while in RUN (exactly N cycles per operation)
//   done       one-cycle pulse when s/cout/ovf have just been updated
//   s          result, holds until the next completion
//   cout       final carry; in sub mode 1 = no borrow (a >= b unsigned)
//   ovf        two's-complement overflow of the signed interpretation
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a request is accepted on any rising edge where start = 1 and
// busy = 0; the matching result is presented with done = 1 exactly N cycles
// later. start while busy = 1 is ignored. done needs no acknowledge.
module alu_suma_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Datapath for the current digit
    logic [DIGIT:0]   sum_full;
    logic [DIGIT-1:0] digit_sum;
    logic             carry_out;
    logic             carry_into_msb;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        sum_full  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        digit_sum = sum_full[DIGIT-1:0];
        carry_out = sum_full[DIGIT];
        // Carry into the digit's top bit recovered from a ^ b ^ sum at that bit;
        // on the last digit this is the carry into the word MSB.
        carry_into_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum_full[DIGIT-1];
        // New digit enters at the top; after N shifts digit 0 sits at bit 0.
        // Written with shifts so DIGIT = WIDTH needs no zero-width slice.
        res_shift = (res_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    // Subtraction as a + ~b + 1
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift;
                carry_d = carry_out;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    s_d     = res_shift;
                    cout_d  = carry_out;
                    ovf_d   = carry_out ^ carry_into_msb;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // busy/done decode directly from the state flop, so they are glitch-free
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule
